fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 10, word width of the FIFO read port and output data.
REQ-002 SHALL have parameter LEN_W, default 4, width of the burst length and remaining-count fields.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle burst request.
REQ-006 SHALL have port burst_len  input  LEN_W  number of words to drain; sampled with start.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current burst.
REQ-008 SHALL have port fifo_empty  input  1  FIFO has no stored words.
REQ-009 SHALL have port fifo_pop  output  1  pop strobe to the FIFO.
REQ-010 SHALL have port fifo_data  input  DATA_W  FIFO read data, valid the cycle after fifo_pop.
REQ-011 SHALL have port out_valid  output  1  out_data holds a word for downstream.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-013 SHALL have port out_data  output  DATA_W  word presented downstream.
REQ-014 SHALL have port busy  output  1  burst in progress, i.e. state not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a burst completes normally.
REQ-016 SHALL have port words_left  output  LEN_W  words still to be delivered in the current burst.

Function
REQ-017 SHALL implement states IDLE, ISSUE, CAPTURE, PRESENT and DONE.
REQ-018 IDLE: on start with burst_len!=0, SHALL latch burst_len into words_left and go to ISSUE.
REQ-019 IDLE: on start with burst_len==0, SHALL go to DONE without popping.
REQ-020 SHALL ignore start in every state except IDLE; words_left SHALL stay unchanged.
REQ-021 ISSUE: fifo_pop SHALL be combinational, equal to (state==ISSUE) && !fifo_empty && !abort.
REQ-022 ISSUE: SHALL go to CAPTURE when fifo_pop=1, and SHALL otherwise stay in ISSUE.
REQ-023 SHALL issue at most one pop per word and SHALL never assert fifo_pop while fifo_empty=1.
REQ-024 CAPTURE: SHALL register fifo_data into out_data at the end of the cycle and go to PRESENT.
REQ-025 Pop-to-out_valid latency SHALL be exactly 2 cycles.
REQ-026 PRESENT: out_valid SHALL be 1, and out_data SHALL remain stable while out_ready=0.
REQ-027 PRESENT with out_ready=1: SHALL decrement words_left, then go to DONE if words_left was 1, else to ISSUE.
REQ-028 out_valid SHALL be 0 in all states other than PRESENT.
REQ-029 Peak throughput SHALL be one word per 3 cycles.
REQ-030 DONE: done SHALL be 1 for exactly one cycle, followed by IDLE.
REQ-031 abort=1 in ISSUE, CAPTURE or PRESENT SHALL go to IDLE next cycle with words_left cleared, done not pulsed and out_valid low.
REQ-032 abort and out_ready in the same PRESENT cycle: abort SHALL win, and the word SHALL count as not delivered.
REQ-033 abort in a CAPTURE cycle SHALL discard the popped word, and this loss SHALL be documented behaviour.
REQ-034 abort in IDLE or DONE SHALL have no effect.
REQ-035 busy SHALL be 1 in ISSUE, CAPTURE, PRESENT and DONE.
REQ-036 words_left SHALL never wrap below 0.

Reset
REQ-037 rst=1 SHALL immediately force state IDLE, out_valid=0, done=0, out_data=0 and words_left=0, with busy=0.
REQ-038 During rst, fifo_pop SHALL be 0 because the state is IDLE.
REQ-039 rst asserted mid-burst SHALL abandon the burst and SHALL take priority over abort.
REQ-040 The first start SHALL be honoured on the first rising edge after rst deasserts.

Verification
REQ-041 Pre-loaded FIFO with 101,202,303; start with burst_len=3 and out_ready=1 -> 3 pops; out_data 101,202,303, each 2 cycles after its pop; done pulses once; words_left 3->2->1->0.
REQ-042 Empty FIFO; start with burst_len=2 -> stays in ISSUE with fifo_pop=0; push 11 -> pop next cycle; out_data=11 and words_left=1 after accept.
REQ-043 Back-pressure: out_ready=0 for 4 cycles in PRESENT with out_data=22 -> out_valid=1 and out_data=22 held all 4 cycles; no extra pop.
REQ-044 start with burst_len=0 -> no pop; done=1 the next cycle; busy high for 1 cycle only.
REQ-045 Burst of 5 with abort asserted together with out_ready on the 2nd word -> IDLE; words_left=0; done stays 0; exactly 2 pops issued.
REQ-046 rst asserted in PRESENT mid-burst -> out_valid and busy drop without waiting for clock; after release, a new start with burst_len=1 delivers the next FIFO word normally.

Source files
------------

// File: rtl/fifo_reader.sv
// Burst reader: pops burst_len words from a FIFO with one-cycle read latency
// and presents each one downstream on a valid/ready port.
module fifo_reader #(
    parameter int DATA_W = 10,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              abort,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_left,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  words_left_nxt;
    logic [DATA_W-1:0] out_data_nxt;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            words_left <= '0;
            out_data   <= '0;
        end else begin
            state      <= state_nxt;
            words_left <= words_left_nxt;
            out_data   <= out_data_nxt;
        end
    end

    // out_valid/out_ready: a word transfers on a cycle where both are high and
    // abort is low; until then out_valid stays high and out_data is frozen.
    // An abort while a word is popped but not yet transferred drops that word.
    always_comb begin
        state_nxt      = state;
        words_left_nxt = words_left;
        out_data_nxt   = out_data;
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        words_left_nxt = burst_len;
                        state_nxt      = ISSUE;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    words_left_nxt = '0;
                    state_nxt      = IDLE;
                end else if (fifo_pop) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    words_left_nxt = '0;
                    state_nxt      = IDLE;
                end else begin
                    out_data_nxt = fifo_data;
                    state_nxt    = PRESENT;
                end
            end
            PRESENT: begin
                if (abort) begin
                    words_left_nxt = '0;
                    state_nxt      = IDLE;
                end else if (out_ready) begin
                    if (words_left > LEN_W'(1)) begin
                        words_left_nxt = words_left - LEN_W'(1);
                        state_nxt      = ISSUE;
                    end else begin
                        // Saturate at zero rather than wrapping.
                        words_left_nxt = '0;
                        state_nxt      = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_pop  = (state == ISSUE) && !fifo_empty && !abort;
    assign out_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and randomized bursts against a queue-based FIFO and word model.
module tb_fifo_reader;
    localparam int DATA_W = 10;
    localparam int LEN_W  = 4;

    logic              clock = 1'b0;
    logic              rst, start, abort, fifo_empty, out_ready;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_pop, out_valid, busy, done;
    logic [DATA_W-1:0] out_data;
    logic [LEN_W-1:0]  words_left;
    logic [2:0]        state_dbg;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] plan_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;
    int pop_count = 0;
    int last_pop_cycle = -10;

    fifo_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clock(clock), .rst(rst), .start(start), .burst_len(burst_len),
        .abort(abort), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .fifo_data(fifo_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done),
        .words_left(words_left), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word();
        logic [DATA_W-1:0] v;
        if (plan_q.size() > 0) v = plan_q.pop_front();
        else v = DATA_W'($urandom);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    // One clock: legality of the pop seen before the edge, then the FIFO
    // model returns the popped word one cycle later.
    task automatic tick();
        logic pop_now;
        #1;
        check("pop_legal", fifo_pop && (fifo_empty || abort), 0);
        pop_now = fifo_pop;
        if (pop_now) last_pop_cycle = cycle;
        @(posedge clock);
        #1;
        cycle++;
        if (pop_now) begin
            fifo_data = fifo_q.pop_front();
            pop_count++;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic sync_lost_words();
        while (exp_q.size() > fifo_q.size()) void'(exp_q.pop_front());
    endtask

    task automatic run_burst(input int len, input int ready_pct, input int abort_word,
                             input int abort_cyc, input int hold_empty, input int stall_n,
                             input bit abort_start);
        int pops0, delivered, exp_left, vcnt;
        bit aborted, finished, word_abort, v_prev, v_now, took;
        pops0 = pop_count;
        delivered = 0;
        exp_left = len;
        aborted = 0;
        finished = 0;
        word_abort = 0;
        v_prev = 0;
        vcnt = 0;
        start = 1'b1;
        burst_len = LEN_W'(len);
        abort = abort_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        burst_len = LEN_W'($urandom);
        check("busy_after_start", busy, 1);
        if (len == 0) begin
            check("zero_len_done", done, 1);
            check("zero_len_left", words_left, 0);
            tick();
            check("zero_len_done_drop", done, 0);
            check("zero_len_busy_drop", busy, 0);
            check("zero_len_pops", pop_count - pops0, 0);
            return;
        end
        check("left_latched", words_left, len);
        for (int it = 0; it < 400 && !aborted && !finished; it++) begin
            out_ready = ($urandom_range(99) < ready_pct);
            abort = (it == abort_cyc);
            start = ($urandom_range(7) == 0);
            if (it >= hold_empty && fifo_q.size() < 12 && $urandom_range(2) == 0) push_word();
            v_now = out_valid;
            if (v_now) begin
                if (!v_prev) begin
                    check("pop_to_valid", cycle - last_pop_cycle, 2);
                    vcnt = 0;
                end
                if (exp_q.size() == 0) check("exp_avail", 0, 1);
                else check("out_data", out_data, exp_q[0]);
                check("pops_in_present", pop_count - pops0, delivered + 1);
                if (vcnt < stall_n) out_ready = 1'b0;
                if (delivered == abort_word) begin
                    abort = 1'b1;
                    out_ready = 1'b1;
                    word_abort = 1;
                end
                vcnt++;
            end
            took = v_now && out_ready && !abort;
            tick();
            if (abort) begin
                aborted = 1;
                exp_left = 0;
            end else if (took) begin
                void'(exp_q.pop_front());
                delivered++;
                exp_left--;
            end
            check("words_left", words_left, exp_left);
            check("done_pulse", done, took && exp_left == 0);
            if (took) check("valid_drop", out_valid, 0);
            if (took && exp_left == 0) finished = 1;
            v_prev = v_now;
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        if (!aborted && !finished) check("burst_timeout", 0, 1);
        if (aborted) begin
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_valid", out_valid, 0);
            if (word_abort) check("abort_pops", pop_count - pops0, delivered + 1);
            tick();
            check("abort_no_done", done, 0);
            sync_lost_words();
        end
        if (finished) begin
            check("done_busy", busy, 1);
            tick();
            check("done_once", done, 0);
            check("idle_busy", busy, 0);
            check("idle_left", words_left, 0);
            check("burst_pops", pop_count - pops0, len);
            check("fifo_consistency", exp_q.size(), fifo_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        burst_len = '0;
        fifo_data = '0;
        fifo_empty = 1'b1;
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_left", words_left, 0);
        check("reset_data", out_data, 0);
        check("reset_pop", fifo_pop, 0);
        check("reset_state_dbg", state_dbg, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        rst = 1'b0;

        // Pre-loaded FIFO, full-rate drain of three words.
        plan_q = '{10'd101, 10'd202, 10'd303};
        repeat (3) push_word();
        run_burst(3, 100, -1, -1, 1000, 0, 0);

        // Start against an empty FIFO; first word arrives later.
        plan_q = '{10'd11};
        run_burst(2, 100, -1, -1, 4, 0, 0);

        // Four cycles of back-pressure on a single word.
        plan_q = '{10'd22};
        push_word();
        run_burst(1, 100, -1, -1, 1000, 4, 0);

        // Zero-length burst.
        run_burst(0, 100, -1, -1, 1000, 0, 0);

        // Abort together with out_ready on the second of five words.
        repeat (5) push_word();
        run_burst(5, 100, 1, -1, 1000, 0, 0);

        // Abort in IDLE alongside start must not block the burst.
        run_burst(2, 80, -1, -1, 0, 0, 1);

        // Asynchronous reset while a word is presented.
        while (fifo_q.size() < 3) push_word();
        start = 1'b1;
        burst_len = LEN_W'(3);
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        check("rst_pre_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_left", words_left, 0);
        check("rst_data", out_data, 0);
        check("rst_pop", fifo_pop, 0);
        @(posedge clock);
        #1;
        cycle++;
        rst = 1'b0;
        sync_lost_words();
        run_burst(1, 100, -1, -1, 1000, 0, 0);

        // Randomized bursts with back-pressure, aborts and late FIFO fills.
        for (int b = 0; b < 25; b++) begin
            run_burst($urandom_range(15, 0), $urandom_range(100, 40),
                      ($urandom_range(3) == 0) ? int'($urandom_range(3, 0)) : -1,
                      ($urandom_range(3) == 0) ? int'($urandom_range(12, 0)) : -1,
                      $urandom_range(3, 0), $urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
